alu_bist: RTL and testbench
===========================

ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 The block SHALL have parameter SEED, default 32'h0000_0001, meaning the LFSR operand-generator seed (0 SHALL be replaced by 1).
REQ-002 The block SHALL have parameter VEC_PER_OP, default 4, meaning vectors per (sign, opcode) pair; legal values are powers of two, 1..64.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, meaning the reset: asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit, meaning the run request, sampled in IDLE or DONE.
REQ-006 The block SHALL have port golden_sig, input, 32 bits, meaning the expected final signature.
REQ-007 The block SHALL have ports alu_a and alu_b, outputs, 32 bits each, meaning the registered operands driven to the ALU.
REQ-008 The block SHALL have ports alu_sel (output, 4 bits), alu_carry_in (output, 1 bit) and alu_sign (output, 1 bit), meaning the registered ALU controls.
REQ-009 The block SHALL have ports alu_out (input, 32 bits), alu_zero (input, 1 bit) and alu_overflow (input, 1 bit), meaning the ALU responses.
REQ-010 The block SHALL have ports busy, done and pass (outputs, 1 bit each) and signature (output, 32 bits), meaning run status and the MISR value.

Function
REQ-011 The FSM SHALL have states IDLE, DRIVE, SAMPLE and DONE.
REQ-012 IDLE/DONE with start=1 SHALL, in one edge, load lfsr=SEED, cnt=0, signature=0, drive vector 0, and go to DRIVE; start=0 holds state.
REQ-013 DRIVE SHALL go to SAMPLE unconditionally, holding all alu_* outputs (one settle cycle).
REQ-014 SAMPLE SHALL apply signature <= {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ alu_out ^ {30'b0, alu_zero, alu_overflow}.
REQ-015 In SAMPLE, if cnt is the last index the FSM SHALL go to DONE; otherwise it SHALL increment cnt, advance the LFSR, drive the next vector, and go to DRIVE.
REQ-016 The LFSR advance SHALL be lfsr = (lfsr<<1) ^ (lfsr[31] ? 32'h0040_0007 : 0).
REQ-017 Each vector SHALL drive: alu_a = lfsr; alu_b = rotate-left(lfsr,7) ^ 32'hFFFF_FFFF; alu_sel = (cnt/VEC_PER_OP) mod 16; alu_sign = cnt/(16*VEC_PER_OP).
REQ-018 The total vector count SHALL be N = 32*VEC_PER_OP, with cnt wrapping never; a run SHALL take exactly 2*N edges from the start edge to DONE entry.
REQ-019 busy SHALL be 1 exactly in DRIVE/SAMPLE; done SHALL be 1 exactly in DONE; pass SHALL equal (signature == golden_sig) while done=1 and 0 otherwise.
REQ-020 start while busy=1 SHALL be ignored; golden_sig SHALL be combinationally compared, not latched.

Reset
REQ-021 Asserting reset at any time, including mid-run, SHALL immediately force IDLE, busy=0, done=0, pass=0, signature=0, all alu_* outputs=0, cnt=0 and lfsr=SEED.
REQ-022 After reset deassertion the block SHALL stay in IDLE until start=1 is sampled.

Configuration
REQ-023 With macro ALU_BIST_CARRY_EN defined, alu_carry_in SHALL equal cnt[0] for each driven vector; without it, alu_carry_in SHALL be constant 0 and its register omitted.

Verification
REQ-024 Reset scenario: assert reset mid-SAMPLE -> all outputs 0 within the same cycle (async); FSM in IDLE; no activity until start.
REQ-025 First vectors (SEED=1, VEC_PER_OP=1): start -> vector 0 shows alu_a=1, alu_b=FFFFFF7F, sel=0, sign=0; vector 1 shows a=2, b=FFFFFEFF, sel=1.
REQ-026 Timing (VEC_PER_OP=1): start pulse -> busy for 64 cycles, done=1 on edge 64 after start edge; vector 16 has alu_sign=1, sel=0.
REQ-027 Stub ALU driving out=0, zero=0, overflow=0 with golden_sig=0 -> signature=0, pass=1; golden_sig=1 -> pass=0.
REQ-028 start held high for the whole run -> single run, no restart until DONE; in DONE, start=1 -> restart, signature cleared, done=0 next cycle.
REQ-029 Real ALU model, two runs with the same SEED -> identical signature; ALU_BIST_CARRY_EN defined -> alu_carry_in alternates 0,1 per vector.

Source files
------------

// File: rtl/alu_bist.sv
// Built-in self test for a 32-bit ALU: an LFSR supplies the operands, sel/sign sweep per vector, and a MISR compacts the responses.
// Optional macro ALU_BIST_CARRY_EN drives alu_carry_in from the vector index LSB; without it the output is tied to 0.
module alu_bist #(
  parameter logic [31:0] SEED       = 32'h0000_0001,
  parameter int          VEC_PER_OP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] golden_sig,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  output logic        alu_carry_in,
  output logic        alu_sign,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature
);

  localparam int          N        = 32 * VEC_PER_OP;
  localparam int          CNT_W    = $clog2(N);
  localparam int          V_SH     = $clog2(VEC_PER_OP);
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] POLY     = 32'h0040_0007;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t             state, state_next;
  logic [31:0]        lfsr;
  logic [CNT_W-1:0]   cnt;
  logic               load, advance, last;
  logic [31:0]        vec_lfsr;
  logic [CNT_W-1:0]   vec_cnt;

  function automatic logic [31:0] lfsr_adv(input logic [31:0] l);
    return (l << 1) ^ (l[31] ? POLY : 32'd0);
  endfunction

  function automatic logic [31:0] operand_b(input logic [31:0] l);
    return {l[24:0], l[31:25]} ^ 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] r,
                                            input logic z, input logic o);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ r ^ {30'b0, z, o};
  endfunction

  assign last = (cnt == CNT_W'(N - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        load       = 1'b1;
        state_next = DRIVE;
      end
      DRIVE:  state_next = SAMPLE;
      SAMPLE: if (last) begin
        state_next = DONE;
      end else begin
        advance    = 1'b1;
        state_next = DRIVE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Next vector source: seed on a fresh run, advanced LFSR otherwise.
  assign vec_lfsr = load ? SEED_EFF : lfsr_adv(lfsr);
  assign vec_cnt  = load ? '0 : cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr      <= SEED_EFF;
      cnt       <= '0;
      signature <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      alu_sign  <= 1'b0;
    end else begin
      if (load) signature <= '0;
      else if (state == SAMPLE) signature <= misr_step(signature, alu_out, alu_zero, alu_overflow);
      if (load || advance) begin
        lfsr     <= vec_lfsr;
        cnt      <= vec_cnt;
        alu_a    <= vec_lfsr;
        alu_b    <= operand_b(vec_lfsr);
        alu_sel  <= vec_cnt[V_SH +: 4];
        alu_sign <= vec_cnt[CNT_W-1];
      end
    end
  end

`ifdef ALU_BIST_CARRY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                alu_carry_in <= 1'b0;
    else if (load || advance) alu_carry_in <= vec_cnt[0];
  end
`else
  assign alu_carry_in = 1'b0;
`endif

  assign busy = (state == DRIVE) || (state == SAMPLE);
  assign done = (state == DONE);
  assign pass = done && (signature == golden_sig);

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: one instance with SEED=1/VEC_PER_OP=1 and one with SEED=8000_0000/VEC_PER_OP=2 to exercise LFSR feedback.
module tb_alu_bist;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, stub = 1'b0;
  logic [31:0] golden_sig = '0, golden2 = '0;

  logic [31:0] a1, b1, out1, sig1, a2, b2, out2, sig2;
  logic [3:0]  sel1, sel2;
  logic        cy1, sg1, z1, o1, busy1, done1, pass1;
  logic        cy2, sg2, z2, o2, busy2, done2, pass2;
  logic [33:0] resp1, resp2;

  int n_cmp = 0, n_err = 0;
  logic [31:0] e1, e2;

`ifdef ALU_BIST_CARRY_EN
  localparam bit CARRY_EN = 1'b1;
`else
  localparam bit CARRY_EN = 1'b0;
`endif

  alu_bist #(.SEED(32'h0000_0001), .VEC_PER_OP(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .golden_sig(golden_sig),
    .alu_a(a1), .alu_b(b1), .alu_sel(sel1), .alu_carry_in(cy1), .alu_sign(sg1),
    .alu_out(out1), .alu_zero(z1), .alu_overflow(o1),
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1));

  alu_bist #(.SEED(32'h8000_0000), .VEC_PER_OP(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .golden_sig(golden2),
    .alu_a(a2), .alu_b(b2), .alu_sel(sel2), .alu_carry_in(cy2), .alu_sign(sg2),
    .alu_out(out2), .alu_zero(z2), .alu_overflow(o2),
    .busy(busy2), .done(done2), .pass(pass2), .signature(sig2));

  always #5 clk = ~clk;

  // Reference ALU: add-with-carry on even sel, xor on odd sel; returns {out, zero, overflow}.
  function automatic logic [33:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] sel, input logic cy, input logic sgn);
    logic [31:0] r;
    r = sel[0] ? (a ^ b) : (a + b + {31'b0, cy});
    return {r, (r == 32'd0), sgn & r[31]};
  endfunction

  always_comb begin
    resp1 = stub ? 34'd0 : alu_fn(a1, b1, sel1, cy1, sg1);
    resp2 = stub ? 34'd0 : alu_fn(a2, b2, sel2, cy2, sg2);
  end
  assign out1 = resp1[33:2];
  assign z1   = resp1[1];
  assign o1   = resp1[0];
  assign out2 = resp2[33:2];
  assign z2   = resp2[1];
  assign o2   = resp2[0];

  function automatic logic [31:0] model_sig(input logic [31:0] seed, input int vpo);
    logic [31:0] l, s, a, b;
    logic [33:0] r;
    logic [3:0]  sel;
    logic        sgn, cy;
    l = (seed == 32'd0) ? 32'd1 : seed;
    s = '0;
    for (int k = 0; k < 32 * vpo; k++) begin
      a   = l;
      b   = {l[24:0], l[31:25]} ^ 32'hFFFF_FFFF;
      sel = 4'((k / vpo) % 16);
      sgn = ((k / (16 * vpo)) % 2) != 0;
      cy  = CARRY_EN && ((k % 2) != 0);
      r   = alu_fn(a, b, sel, cy, sgn);
      s   = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ r[33:2] ^ {30'b0, r[1], r[0]};
      l   = (l << 1) ^ (l[31] ? 32'h0040_0007 : 32'd0);
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    check("rst_busy", 32'(busy1), 0);
    check("rst_done", 32'(done1), 0);
    check("rst_pass", 32'(pass1), 0);
    check("rst_sig", sig1, 0);
    check("rst_a", a1, 0);
    check("rst_b", b1, 0);
    check("rst_sel", 32'(sel1), 0);
    check("rst_sign", 32'(sg1), 0);
    check("rst_carry", 32'(cy1), 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("idle_busy", 32'(busy1), 0);
    check("idle_a", a1, 0);

    e1 = model_sig(32'h0000_0001, 1);
    e2 = model_sig(32'h8000_0000, 2);
    golden_sig = e1;
    golden2    = e2;

    // Run 1: vector contents and cycle timing.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("v0_a", a1, 32'h0000_0001);
    check("v0_b", b1, 32'hFFFF_FF7F);
    check("v0_sel", 32'(sel1), 0);
    check("v0_sign", 32'(sg1), 0);
    check("v0_carry", 32'(cy1), 0);
    check("v0_busy", 32'(busy1), 1);
    check("d2_v0_a", a2, 32'h8000_0000);
    check("d2_v0_b", b2, 32'hFFFF_FFBF);
    tick();
    check("hold_a", a1, 32'h0000_0001);
    check("hold_b", b1, 32'hFFFF_FF7F);
    tick();
    check("v1_a", a1, 32'h0000_0002);
    check("v1_b", b1, 32'hFFFF_FEFF);
    check("v1_sel", 32'(sel1), 1);
    check("v1_carry", 32'(cy1), 32'(CARRY_EN));
    check("d2_v1_a", a2, 32'h0040_0007);
    check("d2_v1_b", b2, 32'hDFFF_FC7F);
    check("d2_v1_sel", 32'(sel2), 0);
    tick();
    tick();
    check("v2_sel", 32'(sel1), 2);
    check("v2_carry", 32'(cy1), 0);
    check("d2_v2_a", a2, 32'h0080_000E);
    check("d2_v2_b", b2, 32'hBFFF_F8FF);
    check("d2_v2_sel", 32'(sel2), 1);
    for (int e = 5; e < 64; e++) begin
      tick();
      check($sformatf("run_busy_%0d", e), 32'(busy1), 1);
      check($sformatf("run_done_%0d", e), 32'(done1), 0);
      if (e == 30) begin
        check("v15_sel", 32'(sel1), 15);
        check("v15_sign", 32'(sg1), 0);
      end
      if (e == 32) begin
        check("v16_sel", 32'(sel1), 0);
        check("v16_sign", 32'(sg1), 1);
      end
    end
    tick();
    check("end_done", 32'(done1), 1);
    check("end_busy", 32'(busy1), 0);
    check("end_sig", sig1, e1);
    check("end_pass", 32'(pass1), 1);
    golden_sig = e1 ^ 32'd1;
    #1;
    check("end_pass_bad_golden", 32'(pass1), 0);
    golden_sig = e1;
    for (int e = 65; e < 128; e++) tick();
    check("d2_busy_127", 32'(busy2), 1);
    tick();
    check("d2_done", 32'(done2), 1);
    check("d2_sig", sig2, e2);
    check("d2_pass", 32'(pass2), 1);

    // Run 2 from DONE: restart clears, same seed gives same signature.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("r2_done", 32'(done1), 0);
    check("r2_busy", 32'(busy1), 1);
    check("r2_sig_clr", sig1, 0);
    repeat (63) tick();
    check("r2_done_early", 32'(done1), 0);
    tick();
    check("r2_done", 32'(done1), 1);
    check("r2_sig", sig1, e1);

    // Stub ALU returning all zeros.
    stub = 1'b1;
    golden_sig = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (64) tick();
    check("stub_done", 32'(done1), 1);
    check("stub_sig", sig1, 0);
    check("stub_pass", 32'(pass1), 1);
    golden_sig = 32'd1;
    #1;
    check("stub_pass_g1", 32'(pass1), 0);

    // Start held high for the whole run.
    stub = 1'b0;
    golden_sig = e1;
    start = 1'b1;
    tick();
    for (int e = 1; e < 64; e++) begin
      tick();
      check($sformatf("held_busy_%0d", e), 32'(busy1), 1);
      if (e == 32) check("held_v16_sign", 32'(sg1), 1);
    end
    tick();
    check("held_done", 32'(done1), 1);
    check("held_sig", sig1, e1);
    tick();
    check("held_restart_done", 32'(done1), 0);
    check("held_restart_busy", 32'(busy1), 1);
    check("held_restart_sig", sig1, 0);
    check("held_restart_a", a1, 32'h0000_0001);
    start = 1'b0;

    // Reset asserted while in SAMPLE.
    repeat (3) tick();
    check("pre_rst_busy", 32'(busy1), 1);
    check("pre_rst_sig", sig1, 32'hFFFF_FF80);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy1), 0);
    check("mid_rst_done", 32'(done1), 0);
    check("mid_rst_pass", 32'(pass1), 0);
    check("mid_rst_sig", sig1, 0);
    check("mid_rst_a", a1, 0);
    check("mid_rst_b", b1, 0);
    check("mid_rst_sel", 32'(sel1), 0);
    check("mid_rst_sign", 32'(sg1), 0);
    #1 reset = 1'b0;
    repeat (4) tick();
    check("post_rst_busy", 32'(busy1), 0);
    check("post_rst_done", 32'(done1), 0);
    check("post_rst_a", a1, 0);
    check("post_rst_sig", sig1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
